// File: rtl/aes_roundtrip_selftest.sv
// Self-test sequencer: walks NUM_VEC plaintexts through external encrypt/decrypt
// cores, checks each round trip and keeps saturating pass/fail counters.
module aes_roundtrip_selftest #(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned NUM_VEC = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [IDX_W-1:0]  vec_idx,
  input  logic [DATA_W-1:0] vec_pt,
  output logic [1:0]        core_mode,
  output logic              enc_start,
  output logic [DATA_W-1:0] enc_in,
  input  logic              enc_done,
  input  logic [DATA_W-1:0] enc_out,
  output logic              dec_start,
  output logic [DATA_W-1:0] dec_in,
  input  logic              dec_done,
  input  logic [DATA_W-1:0] dec_out,
  output logic              busy,
  output logic              done,
  output logic              all_pass,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              timeout_err,
  output logic              mode_err,
  output logic [DATA_W-1:0] last_cipher,
  output logic [7:0]        disp_byte
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENC_REQ,
    S_ENC_WAIT,
    S_DEC_REQ,
    S_DEC_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_vec_idx;
  logic [1:0]          r_core_mode;
  logic [DATA_W-1:0]   r_enc_in;
  logic [DATA_W-1:0]   r_dec_in;
  logic [DATA_W-1:0]   r_last_cipher;
  logic [DATA_W-1:0]   r_dec_cap;
  logic [TMR_W-1:0]    r_timer;
  logic [CNT_W-1:0]    r_pass_count;
  logic [CNT_W-1:0]    r_fail_count;
  logic                r_timeout_err;
  logic                r_done;
  logic                w_start_ok;
  logic                w_tmr_exp;
  logic                w_last_vec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign w_start_ok = start && (mode != 2'b11);
  assign w_tmr_exp  = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last_vec = (r_vec_idx == IDX_W'(NUM_VEC - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start_ok) w_next = S_ENC_REQ;
      S_ENC_REQ:  w_next = S_ENC_WAIT;
      S_ENC_WAIT: begin
        if (enc_done)       w_next = S_DEC_REQ;
        else if (w_tmr_exp) w_next = S_NEXT;
      end
      S_DEC_REQ:  w_next = S_DEC_WAIT;
      S_DEC_WAIT: begin
        if (dec_done)       w_next = S_CHECK;
        else if (w_tmr_exp) w_next = S_NEXT;
      end
      S_CHECK:    w_next = S_NEXT;
      S_NEXT:     w_next = w_last_vec ? S_DONE : S_ENC_REQ;
      S_DONE:     if (!start) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec_idx     <= '0;
      r_core_mode   <= '0;
      r_enc_in      <= '0;
      r_dec_in      <= '0;
      r_last_cipher <= '0;
      r_dec_cap     <= '0;
      r_timer       <= '0;
      r_pass_count  <= '0;
      r_fail_count  <= '0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_core_mode   <= mode;
            r_vec_idx     <= '0;
            r_pass_count  <= '0;
            r_fail_count  <= '0;
            r_timeout_err <= 1'b0;
          end
        end
        S_ENC_REQ: begin
          r_enc_in <= vec_pt;
          r_timer  <= '0;
        end
        S_ENC_WAIT: begin
          if (enc_done) begin
            r_last_cipher <= enc_out;
          end else if (w_tmr_exp) begin
            r_timeout_err <= 1'b1;
            r_fail_count  <= sat_inc(r_fail_count);
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_DEC_REQ: begin
          r_dec_in <= r_last_cipher;
          r_timer  <= '0;
        end
        S_DEC_WAIT: begin
          if (dec_done) begin
            r_dec_cap <= dec_out;
          end else if (w_tmr_exp) begin
            r_timeout_err <= 1'b1;
            r_fail_count  <= sat_inc(r_fail_count);
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_CHECK: begin
          if (r_dec_cap == vec_pt) r_pass_count <= sat_inc(r_pass_count);
          else                     r_fail_count <= sat_inc(r_fail_count);
        end
        S_NEXT: begin
          if (!w_last_vec) r_vec_idx <= r_vec_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Core inputs follow the source directly during the request cycle, then hold.
  assign enc_start   = (r_state == S_ENC_REQ);
  assign enc_in      = enc_start ? vec_pt : r_enc_in;
  assign dec_start   = (r_state == S_DEC_REQ);
  assign dec_in      = dec_start ? r_last_cipher : r_dec_in;

  assign vec_idx     = r_vec_idx;
  assign core_mode   = r_core_mode;
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = r_done;
  assign all_pass    = r_done && (r_fail_count == '0);
  assign pass_count  = r_pass_count;
  assign fail_count  = r_fail_count;
  assign timeout_err = r_timeout_err;
  assign mode_err    = (r_state == S_IDLE) && start && (mode == 2'b11);
  assign last_cipher = r_last_cipher;
  assign disp_byte   = r_last_cipher[7:0];

endmodule

// File: tb/tb_aes_roundtrip_selftest.sv
// Directed bench for aes_roundtrip_selftest with behavioural encrypt/decrypt
// cores and a ciphertext scoreboard checked at each decrypt request.
module tb_aes_roundtrip_selftest;

  localparam int ENC_LAT = 11;
  localparam int DEC_LAT = 5;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [1:0]   vec_idx;
  logic [127:0] vec_pt;
  logic [1:0]   core_mode;
  logic         enc_start;
  logic [127:0] enc_in;
  logic         enc_done = 1'b0;
  logic [127:0] enc_out = '0;
  logic         dec_start;
  logic [127:0] dec_in;
  logic         dec_done = 1'b0;
  logic [127:0] dec_out = '0;
  logic         busy;
  logic         done;
  logic         all_pass;
  logic [7:0]   pass_count;
  logic [7:0]   fail_count;
  logic         timeout_err;
  logic         mode_err;
  logic [127:0] last_cipher;
  logic [7:0]   disp_byte;

  int checks = 0;
  int errors = 0;

  logic [127:0] rom [4];
  logic [1:0]   run_mode = 2'b00;
  logic         enc_en = 1'b1;
  logic         flip_en = 1'b0;

  always #5 clk = ~clk;

  aes_roundtrip_selftest #(
    .DATA_W(128), .NUM_VEC(4), .IDX_W(2), .TIMEOUT(32), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .vec_idx(vec_idx), .vec_pt(vec_pt), .core_mode(core_mode),
    .enc_start(enc_start), .enc_in(enc_in), .enc_done(enc_done), .enc_out(enc_out),
    .dec_start(dec_start), .dec_in(dec_in), .dec_done(dec_done), .dec_out(dec_out),
    .busy(busy), .done(done), .all_pass(all_pass),
    .pass_count(pass_count), .fail_count(fail_count),
    .timeout_err(timeout_err), .mode_err(mode_err),
    .last_cipher(last_cipher), .disp_byte(disp_byte)
  );

  assign vec_pt = rom[vec_idx];

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1:0] m);
    logic [7:0] k;
    k = 8'h3c ^ {6'b0, m};
    if (pt == FIPS_PT) begin
      case (m)
        2'b00:   return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        2'b01:   return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        default: return 128'h8ea2b7ca516745bfeafc49904b496089;
      endcase
    end
    return pt ^ {16{k}};
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [1:0] m);
    logic [7:0] k;
    k = 8'h3c ^ {6'b0, m};
    if (ct == ref_enc(FIPS_PT, m)) return FIPS_PT;
    return ct ^ {16{k}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural cores: fixed latency, not reset, so late pulses survive a DUT reset.
  logic [127:0] e_pt = '0, d_ct = '0;
  int           e_cnt = 0, d_cnt = 0;
  logic [1:0]   d_idx = '0;

  always @(posedge clk) begin
    enc_done <= 1'b0;
    if (enc_start) begin
      e_pt  <= enc_in;
      e_cnt <= ENC_LAT;
    end else if (e_cnt != 0) begin
      e_cnt <= e_cnt - 1;
      if (e_cnt == 1 && enc_en) begin
        enc_done <= 1'b1;
        enc_out  <= ref_enc(e_pt, core_mode);
      end
    end
  end

  always @(posedge clk) begin
    dec_done <= 1'b0;
    if (dec_start) begin
      d_ct  <= dec_in;
      d_idx <= vec_idx;
      d_cnt <= DEC_LAT;
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) begin
        dec_done <= 1'b1;
        dec_out  <= ref_dec(d_ct, core_mode) ^ {127'b0, (flip_en && d_idx == 2'd2)};
      end
    end
  end

  // Scoreboard: expected ciphertext pushed at each encrypt request, popped at decrypt request.
  logic [127:0] sb_q[$];
  logic [127:0] sb_exp;
  int           sb_idx = 0;
  int           n_enc = 0;
  int           n_dec_done = 0;

  always @(negedge clk) begin
    if (!busy) begin
      sb_idx = 0;
      sb_q.delete();
    end
    if (dec_done) n_dec_done++;
    if (enc_start) begin
      n_enc++;
      chk("vec_idx_seq", {126'b0, vec_idx}, 128'(sb_idx));
      chk("core_mode_stable", {126'b0, core_mode}, {126'b0, run_mode});
      chk("enc_in", enc_in, rom[sb_idx[1:0]]);
      sb_q.push_back(ref_enc(rom[sb_idx[1:0]], run_mode));
      sb_idx++;
    end
    if (dec_start) begin
      chk("sb_nonempty", {127'b0, sb_q.size() != 0}, 128'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        chk("dec_in_cipher", dec_in, sb_exp);
      end
    end
  end

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", {127'b0, done}, 128'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_vec_idx"}, {126'b0, vec_idx}, 128'd0);
    chk({tag, "_core_mode"}, {126'b0, core_mode}, 128'd0);
    chk({tag, "_starts"}, {126'b0, enc_start, dec_start}, 128'd0);
    chk({tag, "_enc_in"}, enc_in, 128'd0);
    chk({tag, "_dec_in"}, dec_in, 128'd0);
    chk({tag, "_flags"}, {124'b0, busy, done, all_pass, timeout_err}, 128'd0);
    chk({tag, "_counts"}, {112'b0, pass_count, fail_count}, 128'd0);
    chk({tag, "_last_cipher"}, last_cipher, 128'd0);
  endtask

  task automatic run_and_finish(input logic [1:0] m, input string tag);
    int n;
    run_mode = m;
    mode     = m;
    start    = 1'b1;
    wait_done(400, n);
    chk({tag, "_core_mode"}, {126'b0, core_mode}, {126'b0, m});
  endtask

  int n, enc0, dd0;
  logic saw_start;

  initial begin
    rom[0] = 128'h0123456789abcdeffedcba9876543210;
    rom[1] = 128'hdeadbeefcafef00d0badc0de12345678;
    rom[2] = 128'h3243f6a8885a308d313198a2e0370734;
    rom[3] = FIPS_PT;
    reset = 1'b1; start = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    chk("reset_mode_err", {127'b0, mode_err}, 128'd0);

    // AES-128 run, all vectors round-trip
    enc0 = n_enc;
    run_and_finish(2'b00, "m128");
    chk("m128_pass", {120'b0, pass_count}, 128'd4);
    chk("m128_fail", {120'b0, fail_count}, 128'd0);
    chk("m128_all_pass", {127'b0, all_pass}, 128'd1);
    chk("m128_tmo", {127'b0, timeout_err}, 128'd0);
    chk("m128_last_cipher", last_cipher, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("m128_disp", {120'b0, disp_byte}, 128'h5a);
    chk("m128_enc_count", 128'(n_enc - enc0), 128'd4);
    // start held in DONE keeps done; dropping it returns to IDLE next cycle
    repeat (3) @(negedge clk);
    chk("done_hold", {126'b0, done, busy}, 128'b10);
    start = 1'b0;
    @(negedge clk);
    chk("done_release", {126'b0, done, busy}, 128'b00);
    chk("held_counts", {120'b0, pass_count}, 128'd4);

    // AES-192 with an illegal mode change mid-run
    run_mode = 2'b01; mode = 2'b01; start = 1'b1;
    repeat (4) @(negedge clk);
    mode = 2'b11;
    wait_done(400, n);
    chk("m192_core_mode", {126'b0, core_mode}, 128'd1);
    chk("m192_last_cipher", last_cipher, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("m192_all_pass", {127'b0, all_pass}, 128'd1);
    start = 1'b0;
    @(negedge clk);

    run_and_finish(2'b10, "m256");
    chk("m256_last_cipher", last_cipher, 128'h8ea2b7ca516745bfeafc49904b496089);
    chk("m256_disp", {120'b0, disp_byte}, 128'h89);
    chk("m256_all_pass", {127'b0, all_pass}, 128'd1);
    start = 1'b0;
    @(negedge clk);

    // Decrypt corrupts vector 2 only
    flip_en = 1'b1;
    enc0 = n_enc;
    run_and_finish(2'b00, "flip");
    chk("flip_pass", {120'b0, pass_count}, 128'd3);
    chk("flip_fail", {120'b0, fail_count}, 128'd1);
    chk("flip_all_pass", {127'b0, all_pass}, 128'd0);
    chk("flip_tmo", {127'b0, timeout_err}, 128'd0);
    chk("flip_enc_count", 128'(n_enc - enc0), 128'd4);
    flip_en = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // Encrypt core never answers: every vector times out after 32 wait cycles
    enc_en = 1'b0;
    run_mode = 2'b00; mode = 2'b00; start = 1'b1;
    repeat (33) @(negedge clk);
    chk("tmo_not_yet", {127'b0, timeout_err}, 128'd0);
    @(negedge clk);
    chk("tmo_set", {127'b0, timeout_err}, 128'd1);
    wait_done(400, n);
    chk("tmo_latency", 128'(34 + n), 128'd137);
    chk("tmo_fail", {120'b0, fail_count}, 128'd4);
    chk("tmo_pass", {120'b0, pass_count}, 128'd0);
    chk("tmo_all_pass", {127'b0, all_pass}, 128'd0);
    enc_en = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // Illegal mode stays in IDLE without requesting the core
    mode = 2'b11; start = 1'b1;
    saw_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (enc_start || busy) saw_start = 1'b1;
    end
    chk("mode_err", {127'b0, mode_err}, 128'd1);
    chk("mode_err_idle", {127'b0, saw_start}, 128'd0);

    // Reset while waiting on decrypt; the late dec_done must be ignored
    run_mode = 2'b00; mode = 2'b00;
    n = 0;
    while (dec_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dec_start_seen", {127'b0, dec_start}, 128'd1);
    @(negedge clk);
    dd0 = n_dec_done;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midrun");
    repeat (8) @(negedge clk);
    chk("late_dec_pulse", {127'b0, n_dec_done != dd0}, 128'd1);
    check_reset_state("late_dec");

    // Restart: counters clear and a fresh run completes
    run_and_finish(2'b00, "restart");
    chk("restart_pass", {120'b0, pass_count}, 128'd4);
    chk("restart_all_pass", {127'b0, all_pass}, 128'd1);
    start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
